// File: rtl/excp_mtimer.sv
`default_nettype none
// ============================================================================
// Module   : excp_mtimer
// Brief    : Machine timer (shared 64-bit mtime, per-channel mtimecmp) and
//            software-interrupt (msip) unit behind a 32-bit req/rsp port.
//            Optional macro EXCP_MTIME_SNAP_EN: word-0 reads snapshot
//            mtime[63:32] so that a following word-1 read is carry-atomic.
// Revision : 1.0 - initial release
// ============================================================================
module excp_mtimer #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 4,
    parameter int PRESC_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [NUM_CH-1:0] tmr_irq,
    output logic [NUM_CH-1:0] sft_irq
);

    // One extra address bit so the map size itself is representable.
    localparam logic [ADDR_W:0] c_num_regs     = (ADDR_W+1)'(4 + 2*NUM_CH);
    localparam logic [ADDR_W:0] c_addr_mtime_lo = (ADDR_W+1)'(0);
    localparam logic [ADDR_W:0] c_addr_mtime_hi = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] c_addr_ctrl     = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0] c_addr_msip     = (ADDR_W+1)'(3);
    localparam logic [15:0]     c_presc_last    = 16'(PRESC_DIV - 1);

    logic [ADDR_W:0]   w_addr;
    logic              w_rd;
    logic              w_wr;
    logic              w_mapped;
    logic              w_wr_mtime_lo;
    logic              w_wr_mtime_hi;
    logic              w_wr_ctrl;
    logic              w_wr_msip;
    logic              w_tick;
    logic [31:0]       w_rdata;
    logic [31:0]       w_mtime_hi_rd;
    logic [63:0]       w_cmp [NUM_CH];

    logic [63:0]       r_mtime;
    logic [15:0]       r_presc_cnt;
    logic              r_cnt_en;
    logic [NUM_CH-1:0] r_msip;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;

    assign w_addr        = {1'b0, req_addr};
    assign w_rd          = req_valid & ~req_wen;
    assign w_wr          = req_valid & req_wen;
    assign w_mapped      = (w_addr < c_num_regs);
    assign w_wr_mtime_lo = w_wr && (w_addr == c_addr_mtime_lo);
    assign w_wr_mtime_hi = w_wr && (w_addr == c_addr_mtime_hi);
    assign w_wr_ctrl     = w_wr && (w_addr == c_addr_ctrl);
    assign w_wr_msip     = w_wr && (w_addr == c_addr_msip);
    assign w_tick        = r_cnt_en && (r_presc_cnt == c_presc_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc_cnt <= '0;
        end else if (r_cnt_en) begin
            r_presc_cnt <= w_tick ? 16'd0 : r_presc_cnt + 16'd1;
        end
    end

    // A software write to either half wins over a same-cycle tick; the low
    // word is written in isolation and never carries into the high word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtime <= '0;
        end else if (w_wr_mtime_lo) begin
            r_mtime[31:0] <= req_wdata;
        end else if (w_wr_mtime_hi) begin
            r_mtime[63:32] <= req_wdata;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_en <= 1'b1;
            r_msip   <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_cnt_en <= req_wdata[0];
            end
            if (w_wr_msip) begin
                r_msip <= req_wdata[NUM_CH-1:0];
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [ADDR_W:0] c_addr_cmp_lo = (ADDR_W+1)'(4 + 2*k);
        localparam logic [ADDR_W:0] c_addr_cmp_hi = (ADDR_W+1)'(5 + 2*k);

        logic [63:0] r_cmp;
        logic        r_irq;

        // Comparison is live against the current halves, so a half-written
        // compare value can briefly assert the interrupt.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cmp <= '1;
                r_irq <= 1'b0;
            end else begin
                if (w_wr && (w_addr == c_addr_cmp_lo)) begin
                    r_cmp[31:0] <= req_wdata;
                end
                if (w_wr && (w_addr == c_addr_cmp_hi)) begin
                    r_cmp[63:32] <= req_wdata;
                end
                r_irq <= (r_mtime >= r_cmp);
            end
        end

        assign w_cmp[k]   = r_cmp;
        assign tmr_irq[k] = r_irq;
    end

`ifdef EXCP_MTIME_SNAP_EN
    logic [31:0] r_snap_hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap_hi <= '0;
        end else if (w_rd && (w_addr == c_addr_mtime_lo)) begin
            r_snap_hi <= r_mtime[63:32];
        end
    end

    assign w_mtime_hi_rd = r_snap_hi;
`else
    assign w_mtime_hi_rd = r_mtime[63:32];
`endif

    always_comb begin
        w_rdata = '0;
        if (w_addr == c_addr_mtime_lo) begin
            w_rdata = r_mtime[31:0];
        end else if (w_addr == c_addr_mtime_hi) begin
            w_rdata = w_mtime_hi_rd;
        end else if (w_addr == c_addr_ctrl) begin
            w_rdata = {31'd0, r_cnt_en};
        end else if (w_addr == c_addr_msip) begin
            w_rdata = 32'(r_msip);
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_addr == (ADDR_W+1)'(4 + 2*k)) begin
                w_rdata = w_cmp[k][31:0];
            end
            if (w_addr == (ADDR_W+1)'(5 + 2*k)) begin
                w_rdata = w_cmp[k][63:32];
            end
        end
    end

    // Read data is captured at the accepting edge, i.e. before any
    // same-edge tick or write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= req_valid;
            r_rsp_err   <= req_valid && !w_mapped;
            r_rsp_rdata <= (w_rd && w_mapped) ? w_rdata : 32'd0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign sft_irq   = r_msip;

endmodule
`default_nettype wire

// File: tb/tb_excp_mtimer.sv
`default_nettype none
// Directed bench for excp_mtimer: instance "dut" runs PRESC_DIV=1, instance
// "dut4" runs PRESC_DIV=4 for the prescaler/enable scenario.
module tb_excp_mtimer;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_valid, a_wen;
    logic [3:0]  a_addr;
    logic [31:0] a_wdata;
    logic        a_rvalid, a_err;
    logic [31:0] a_rdata;
    logic [1:0]  a_tirq, a_sirq;

    logic        b_valid, b_wen;
    logic [3:0]  b_addr;
    logic [31:0] b_wdata;
    logic        b_rvalid, b_err;
    logic [31:0] b_rdata;
    logic [1:0]  b_tirq, b_sirq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    excp_mtimer #(.NUM_CH(2), .ADDR_W(4), .PRESC_DIV(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(a_valid), .req_wen(a_wen), .req_addr(a_addr), .req_wdata(a_wdata),
        .rsp_valid(a_rvalid), .rsp_rdata(a_rdata), .rsp_err(a_err),
        .tmr_irq(a_tirq), .sft_irq(a_sirq)
    );

    excp_mtimer #(.NUM_CH(2), .ADDR_W(4), .PRESC_DIV(4)) dut4 (
        .clk(clk), .rst(rst),
        .req_valid(b_valid), .req_wen(b_wen), .req_addr(b_addr), .req_wdata(b_wdata),
        .rsp_valid(b_rvalid), .rsp_rdata(b_rdata), .rsp_err(b_err),
        .tmr_irq(b_tirq), .sft_irq(b_sirq)
    );

    // Called at a negedge: presents one request, lets it be accepted at the
    // next posedge, and returns the response seen at the following negedge.
    task automatic bus(input bit sel, input bit wen, input logic [3:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic err, output logic vld);
        if (!sel) begin
            a_valid = 1'b1; a_wen = wen; a_addr = addr; a_wdata = wd;
        end else begin
            b_valid = 1'b1; b_wen = wen; b_addr = addr; b_wdata = wd;
        end
        @(posedge clk);
        @(negedge clk);
        if (!sel) begin
            rd = a_rdata; err = a_err; vld = a_rvalid;
            a_valid = 1'b0; a_wen = 1'b0;
        end else begin
            rd = b_rdata; err = b_err; vld = b_rvalid;
            b_valid = 1'b0; b_wen = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic err, vld;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({a_rvalid, a_err, a_rdata, a_tirq, a_sirq} !== 37'd0) begin
            bad++; $display("FAIL reset_outputs: got %h expected 0", {a_rvalid, a_err, a_rdata, a_tirq, a_sirq});
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if ({a_tirq, a_sirq} !== 4'b0000) begin
            bad++; $display("FAIL reset_irqs: got %b expected 0000", {a_tirq, a_sirq});
        end
        bus(0, 0, 4'd0, 32'd0, rd, err, vld);
        total++;
        if ({vld, err, rd} !== {1'b1, 1'b0, 32'd10}) begin
            bad++; $display("FAIL reset_mtime10: got v=%b e=%b d=%h expected v=1 e=0 d=0000000a", vld, err, rd);
        end
        @(negedge clk);
        total++;
        if (a_rvalid !== 1'b0) begin
            bad++; $display("FAIL rsp_pulse: got %b expected 0", a_rvalid);
        end
        bus(0, 0, 4'd4, 32'd0, rd, err, vld);
        total++;
        if (rd !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL reset_cmp0_lo: got %h expected ffffffff", rd);
        end
    endtask

    task automatic test_compare();
        logic [31:0] rd; logic err, vld;
        bus(0, 1, 4'd0, 32'd0, rd, err, vld);
        bus(0, 1, 4'd5, 32'd0, rd, err, vld);
        bus(0, 1, 4'd4, 32'd20, rd, err, vld);
        total++;
        if ({vld, err, rd} !== {1'b1, 1'b0, 32'd0}) begin
            bad++; $display("FAIL write_rsp: got v=%b e=%b d=%h expected v=1 e=0 d=0", vld, err, rd);
        end
        repeat (18) @(negedge clk);
        total++;
        if (a_tirq !== 2'b00) begin
            bad++; $display("FAIL irq_early: got %b expected 00", a_tirq);
        end
        @(negedge clk);
        total++;
        if (a_tirq !== 2'b01) begin
            bad++; $display("FAIL irq_rise: got %b expected 01", a_tirq);
        end
        bus(0, 1, 4'd4, 32'hFFFF_FFFF, rd, err, vld);
        total++;
        if (a_tirq !== 2'b01) begin
            bad++; $display("FAIL irq_hold_in_rsp: got %b expected 01", a_tirq);
        end
        @(negedge clk);
        total++;
        if (a_tirq !== 2'b00) begin
            bad++; $display("FAIL irq_clear: got %b expected 00", a_tirq);
        end
    endtask

    task automatic test_collision();
        logic [31:0] rd; logic err, vld;
        bus(0, 1, 4'd0, 32'd100, rd, err, vld);
        bus(0, 0, 4'd0, 32'd0, rd, err, vld);
        total++;
        if (rd !== 32'd100) begin
            bad++; $display("FAIL collide_first: got %0d expected 100", rd);
        end
        bus(0, 0, 4'd0, 32'd0, rd, err, vld);
        total++;
        if ({vld, rd} !== {1'b1, 32'd101}) begin
            bad++; $display("FAIL back_to_back: got v=%b d=%0d expected v=1 d=101", vld, rd);
        end
        repeat (3) @(negedge clk);
        bus(0, 0, 4'd0, 32'd0, rd, err, vld);
        total++;
        if (rd !== 32'd105) begin
            bad++; $display("FAIL collide_later: got %0d expected 105", rd);
        end
    endtask

    task automatic test_carry();
        logic [31:0] rd; logic err, vld;
        logic [31:0] exp_hi;
        bus(0, 1, 4'd0, 32'hFFFF_FFFE, rd, err, vld);
        bus(0, 1, 4'd1, 32'd5, rd, err, vld);
        @(negedge clk);
        bus(0, 0, 4'd0, 32'd0, rd, err, vld);
        total++;
        if (rd !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL carry_lo: got %h expected ffffffff", rd);
        end
        bus(0, 0, 4'd1, 32'd0, rd, err, vld);
`ifdef EXCP_MTIME_SNAP_EN
        exp_hi = 32'd5;
`else
        exp_hi = 32'd6;
`endif
        total++;
        if (rd !== exp_hi) begin
            bad++; $display("FAIL carry_hi: got %h expected %h", rd, exp_hi);
        end
        bus(0, 0, 4'd0, 32'd0, rd, err, vld);
        total++;
        if (rd !== 32'd1) begin
            bad++; $display("FAIL lo_wrap: got %h expected 00000001", rd);
        end
    endtask

    task automatic test_presc();
        logic [31:0] rd, prev, cur, v; logic err, vld;
        logic [31:0] r2, r3;
        bit found;
        bus(1, 0, 4'd0, 32'd0, prev, err, vld);
        repeat (11) @(negedge clk);
        bus(1, 0, 4'd0, 32'd0, cur, err, vld);
        total++;
        if (cur - prev !== 32'd3) begin
            bad++; $display("FAIL presc_12cyc: got delta %0d expected 3", cur - prev);
        end
        // Locate a tick edge so the prescaler phase is known exactly.
        found = 1'b0;
        v = '0;
        bus(1, 0, 4'd0, 32'd0, prev, err, vld);
        for (int i = 0; i < 8 && !found; i++) begin
            bus(1, 0, 4'd0, 32'd0, cur, err, vld);
            if (cur != prev) begin
                found = 1'b1;
                v = prev;
            end else begin
                prev = cur;
            end
        end
        total++;
        if (!found || cur !== v + 32'd1) begin
            bad++; $display("FAIL presc_tick_find: got found=%b step=%h expected found=1 step=%h", found, cur, v + 32'd1);
        end
        bus(1, 1, 4'd2, 32'd0, rd, err, vld);
        bus(1, 0, 4'd0, 32'd0, rd, err, vld);
        total++;
        if (rd !== v + 32'd1) begin
            bad++; $display("FAIL disable_val: got %h expected %h", rd, v + 32'd1);
        end
        bus(1, 0, 4'd2, 32'd0, rd, err, vld);
        total++;
        if (rd !== 32'd0) begin
            bad++; $display("FAIL ctrl_read0: got %h expected 0", rd);
        end
        repeat (20) @(negedge clk);
        bus(1, 0, 4'd0, 32'd0, rd, err, vld);
        total++;
        if (rd !== v + 32'd1) begin
            bad++; $display("FAIL disable_hold: got %h expected %h", rd, v + 32'd1);
        end
        bus(1, 1, 4'd2, 32'd1, rd, err, vld);
        bus(1, 0, 4'd0, 32'd0, rd, err, vld);
        bus(1, 0, 4'd0, 32'd0, r2, err, vld);
        bus(1, 0, 4'd0, 32'd0, r3, err, vld);
        total++;
        if ({r2, r3} !== {v + 32'd1, v + 32'd2}) begin
            bad++; $display("FAIL resume_phase: got %h,%h expected %h,%h", r2, r3, v + 32'd1, v + 32'd2);
        end
    endtask

    task automatic test_msip_err();
        logic [31:0] rd; logic err, vld;
        total++;
        if (a_sirq !== 2'b00) begin
            bad++; $display("FAIL sft_pre: got %b expected 00", a_sirq);
        end
        bus(0, 1, 4'd3, 32'h0000_0002, rd, err, vld);
        total++;
        if (a_sirq !== 2'b10) begin
            bad++; $display("FAIL sft_irq: got %b expected 10", a_sirq);
        end
        bus(0, 0, 4'd3, 32'd0, rd, err, vld);
        total++;
        if (rd !== 32'd2) begin
            bad++; $display("FAIL msip_read: got %h expected 00000002", rd);
        end
        bus(0, 0, 4'd15, 32'd0, rd, err, vld);
        total++;
        if ({vld, err, rd} !== {1'b1, 1'b1, 32'd0}) begin
            bad++; $display("FAIL unmapped_read: got v=%b e=%b d=%h expected v=1 e=1 d=0", vld, err, rd);
        end
        bus(0, 1, 4'd15, 32'hFFFF_FFFF, rd, err, vld);
        total++;
        if ({vld, err, rd} !== {1'b1, 1'b1, 32'd0}) begin
            bad++; $display("FAIL unmapped_write: got v=%b e=%b d=%h expected v=1 e=1 d=0", vld, err, rd);
        end
        bus(0, 0, 4'd3, 32'd0, rd, err, vld);
        total++;
        if ({err, rd, a_sirq} !== {1'b0, 32'd2, 2'b10}) begin
            bad++; $display("FAIL unmapped_nochange: got e=%b d=%h s=%b expected e=0 d=2 s=10", err, rd, a_sirq);
        end
        bus(0, 0, 4'd2, 32'd0, rd, err, vld);
        total++;
        if (rd !== 32'd1) begin
            bad++; $display("FAIL ctrl_read1: got %h expected 00000001", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err, vld;
        a_valid = 1'b1; a_wen = 1'b0; a_addr = 4'd0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({a_rvalid, a_sirq, a_tirq} !== 5'd0) begin
            bad++; $display("FAIL mid_reset_clear: got %b expected 00000", {a_rvalid, a_sirq, a_tirq});
        end
        a_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (a_rvalid !== 1'b0) begin
            bad++; $display("FAIL mid_reset_norsp: got %b expected 0", a_rvalid);
        end
        bus(0, 0, 4'd3, 32'd0, rd, err, vld);
        total++;
        if (rd !== 32'd0) begin
            bad++; $display("FAIL mid_reset_msip: got %h expected 0", rd);
        end
        bus(0, 0, 4'd4, 32'd0, rd, err, vld);
        total++;
        if (rd !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL mid_reset_cmp: got %h expected ffffffff", rd);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_wen = 1'b0; a_addr = '0; a_wdata = '0;
        b_valid = 1'b0; b_wen = 1'b0; b_addr = '0; b_wdata = '0;
        test_reset();
        test_compare();
        test_collision();
        test_carry();
        test_presc();
        test_msip_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish before 100000");
        $fatal(1);
    end

endmodule
`default_nettype wire
